// File: rtl/div_color_sampler_pkg.sv
// Shared widths and FSM encoding for the reference-colour sampler.
package div_color_sampler_pkg;

    localparam int unsigned COLOR_WIDTH = 6;
    localparam int unsigned COORD_W     = 12;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACC,
        DIV,
        UPD,
        ERR
    } state_e;

endpackage

// File: rtl/div_color_sampler_div.sv
// Restoring unsigned divider producing one quotient bit per cycle, MSB first.
// Assumes dividend < divisor << Q_W so that Q_W quotient bits are enough.
module div_color_sampler_div
    import div_color_sampler_pkg::*;
#(
    parameter int unsigned DVD_W = 32,
    parameter int unsigned DVS_W = 28,
    parameter int unsigned Q_W   = 7
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic [Q_W-1:0]   o_quotient,
    output logic             o_done
);

    localparam int unsigned IW    = DVS_W + Q_W;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    logic [IW-1:0]    r_rem;
    logic [IW-1:0]    r_dsh;
    logic [CNT_W-1:0] r_cnt;
    logic [Q_W-1:0]   r_q;
    logic             r_done;

    logic [IW-1:0]    w_rem_in;
    logic [IW-1:0]    w_dsh_in;
    logic [IW-1:0]    w_rem_nxt;
    logic             w_bit;

    // The start cycle already resolves the top quotient bit.
    always_comb begin
        w_rem_in  = i_start ? IW'(i_dividend) : r_rem;
        w_dsh_in  = i_start ? (IW'(i_divisor) << (Q_W - 1)) : r_dsh;
        w_bit     = (w_rem_in >= w_dsh_in);
        w_rem_nxt = w_bit ? (w_rem_in - w_dsh_in) : w_rem_in;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= w_rem_nxt;
                r_dsh <= w_dsh_in >> 1;
                r_q   <= Q_W'(w_bit);
                r_cnt <= CNT_W'(Q_W - 1);
            end else if (r_cnt != '0) begin
                r_rem  <= w_rem_nxt;
                r_dsh  <= r_dsh >> 1;
                r_q    <= {r_q[Q_W-2:0], w_bit};
                r_cnt  <= r_cnt - 1'b1;
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_quotient = r_q;
    assign o_done     = r_done;

endmodule

// File: rtl/div_color_sampler.sv
// Captures a window's average chromaticity over one frame and publishes it as
// the reference R0/G0/B0 for the colour-division stage.
module div_color_sampler
    import div_color_sampler_pkg::*;
#(
    parameter int unsigned     C_W    = COLOR_WIDTH,
    parameter int unsigned     IMG_W  = 640,
    parameter int unsigned     ACC_W  = 20,
    parameter logic [C_W-1:0]  DEF_R0 = C_W'(21),
    parameter logic [C_W-1:0]  DEF_G0 = C_W'(21),
    parameter logic [C_W-1:0]  DEF_B0 = C_W'(21)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [C_W-1:0]     i_R,
    input  logic [C_W-1:0]     i_G,
    input  logic [C_W-1:0]     i_B,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    input  logic               i_trigger,
    output logic [C_W-1:0]     o_R0,
    output logic [C_W-1:0]     o_G0,
    output logic [C_W-1:0]     o_B0,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int unsigned SUM_W = C_W + ACC_W;
    localparam int unsigned TOT_W = SUM_W + 2;
    localparam int unsigned DVD_W = SUM_W + C_W;
    localparam int unsigned Q_W   = C_W + 1;
    localparam logic [ACC_W-1:0] CNT_MAX = {ACC_W{1'b1}};

    state_e r_state, w_state_nxt;

    logic [COORD_W-1:0] r_x, r_y, w_x, w_y;
    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [SUM_W-1:0]   r_sum_r, r_sum_g, r_sum_b;
    logic [ACC_W-1:0]   r_cnt;
    logic [C_W-1:0]     r_stg_r, r_stg_g;
    logic [C_W-1:0]     r_R0, r_G0, r_B0;
    logic               r_busy, r_done, r_err, r_kick;
    logic [1:0]         r_ch;

    logic               w_in_win, w_acc_en;
    logic [TOT_W-1:0]   w_total;
    logic [1:0]         w_sel;
    logic [SUM_W-1:0]   w_sum_sel;
    logic [DVD_W-1:0]   w_dividend;
    logic [Q_W-1:0]     w_quot;
    logic [C_W-1:0]     w_q_sat;
    logic               w_div_start, w_div_done;

    // Position of the current pixel; r_x/r_y hold the position of the next one.
    always_comb begin
        w_x      = i_sof ? '0 : r_x;
        w_y      = i_sof ? '0 : r_y;
        w_in_win = (w_x >= r_x0) && (w_x <= r_x1) && (w_y >= r_y0) && (w_y <= r_y1);
        w_total  = TOT_W'(r_sum_r) + TOT_W'(r_sum_g) + TOT_W'(r_sum_b);
    end

    // Channel fed to the divider: R on the kick, then the channel after the one finishing.
    always_comb begin
        w_sel       = r_kick ? 2'd0 : (r_ch + 2'd1);
        w_div_start = r_kick || (w_div_done && (r_state == DIV) && (r_ch != 2'd2));
        case (w_sel)
            2'd0:    w_sum_sel = r_sum_r;
            2'd1:    w_sum_sel = r_sum_g;
            default: w_sum_sel = r_sum_b;
        endcase
        w_dividend = {w_sum_sel, {C_W{1'b0}}};
        w_q_sat    = w_quot[C_W] ? {C_W{1'b1}} : w_quot[C_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_en    = 1'b0;
        case (r_state)
            IDLE: if (i_trigger) w_state_nxt = ARM;
            ARM: begin
                if (i_valid && i_sof) begin
                    w_state_nxt = ACC;
                    w_acc_en    = w_in_win;
                end
            end
            ACC: begin
                if (i_valid) begin
                    if (i_sof)
                        w_state_nxt = ((r_cnt == '0) || (w_total == '0)) ? ERR : DIV;
                    else
                        w_acc_en = w_in_win && (r_cnt != CNT_MAX);
                end
            end
            DIV:     if (w_div_done && (r_ch == 2'd2)) w_state_nxt = UPD;
            UPD:     w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_cnt   <= '0;
            r_stg_r <= '0;
            r_stg_g <= '0;
            r_ch    <= '0;
            r_kick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_R0    <= DEF_R0;
            r_G0    <= DEF_G0;
            r_B0    <= DEF_B0;
        end else begin
            if (i_valid) begin
                if (w_x == COORD_W'(IMG_W - 1)) begin
                    r_x <= '0;
                    r_y <= w_y + 1'b1;
                end else begin
                    r_x <= w_x + 1'b1;
                    r_y <= w_y;
                end
            end

            if ((r_state == IDLE) && i_trigger) begin
                r_x0    <= i_x0;
                r_y0    <= i_y0;
                r_x1    <= i_x1;
                r_y1    <= i_y1;
                r_sum_r <= '0;
                r_sum_g <= '0;
                r_sum_b <= '0;
                r_cnt   <= '0;
            end else if (w_acc_en) begin
                r_sum_r <= r_sum_r + SUM_W'(i_R);
                r_sum_g <= r_sum_g + SUM_W'(i_G);
                r_sum_b <= r_sum_b + SUM_W'(i_B);
                r_cnt   <= r_cnt + 1'b1;
            end

            r_kick <= (r_state == ACC) && (w_state_nxt == DIV);
            if ((r_state == ACC) && (w_state_nxt == DIV)) begin
                r_ch <= '0;
            end else if (w_div_done && (r_state == DIV)) begin
                if (r_ch == 2'd0) r_stg_r <= w_q_sat;
                if (r_ch == 2'd1) r_stg_g <= w_q_sat;
                r_ch <= r_ch + 2'd1;
            end

            // Blue lands straight from the divider so all three change on one edge.
            if (w_state_nxt == UPD) begin
                r_R0 <= r_stg_r;
                r_G0 <= r_stg_g;
                r_B0 <= w_q_sat;
            end

            r_busy <= (w_state_nxt == ARM) || (w_state_nxt == ACC) || (w_state_nxt == DIV);
            r_done <= (w_state_nxt == UPD);
            r_err  <= (w_state_nxt == ERR);
        end
    end

    div_color_sampler_div #(
        .DVD_W (DVD_W),
        .DVS_W (TOT_W),
        .Q_W   (Q_W)
    ) u_div (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_total),
        .o_quotient (w_quot),
        .o_done     (w_div_done)
    );

    assign o_R0   = r_R0;
    assign o_G0   = r_G0;
    assign o_B0   = r_B0;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_div_color_sampler.sv
// Randomized frame-level bench for div_color_sampler with a window-average reference model.
module tb_div_color_sampler;

    localparam int IMG_W  = 8;
    localparam int LINES  = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        i_valid, i_sof, i_trigger;
    logic [5:0]  i_R, i_G, i_B;
    logic [11:0] i_x0, i_y0, i_x1, i_y1;
    logic [5:0]  o_R0, o_G0, o_B0;
    logic        o_busy, o_done, o_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_r = 21, exp_g = 21, exp_b = 21;

    always #5 sys_clk = ~sys_clk;

    div_color_sampler #(.IMG_W(IMG_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_R       (i_R),
        .i_G       (i_G),
        .i_B       (i_B),
        .i_x0      (i_x0),
        .i_y0      (i_y0),
        .i_x1      (i_x1),
        .i_y1      (i_y1),
        .i_trigger (i_trigger),
        .o_R0      (o_R0),
        .o_G0      (o_G0),
        .o_B0      (o_B0),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int pick(input int v);
        return (v < 0) ? int'($urandom_range(0, 63)) : v;
    endfunction

    // One full capture: trigger, one accumulated frame, closing sof, then watch 40 cycles.
    // Colour args < 0 mean random per pixel; junk drives trigger/pixel noise in DIV; rst_at>0 resets mid-DIV.
    task automatic do_capture(input string tag, input int x0, input int y0, input int x1, input int y1,
                              input int ir, input int ig, input int ib,
                              input int orr, input int og, input int ob,
                              input bit junk, input int rst_at);
        longint sr, sg, sb, tot;
        int cnt, ndone, nerr, tdone, terr, r, g, b;
        bit inw, exp_err;
        sr = 0; sg = 0; sb = 0; cnt = 0; ndone = 0; nerr = 0; tdone = -1; terr = -1;

        tick();
        i_valid = 0; i_sof = 0; i_trigger = 1;
        i_x0 = 12'(x0); i_y0 = 12'(y0); i_x1 = 12'(x1); i_y1 = 12'(y1);
        tick();
        i_trigger = 0;
        i_x0 = 12'($urandom_range(0, 7)); i_y0 = 12'($urandom_range(0, 3));
        i_x1 = 12'($urandom_range(0, 7)); i_y1 = 12'($urandom_range(0, 3));
        @(negedge sys_clk);
        check({tag, " busy_armed"}, o_busy, 1);

        for (int y = 0; y < LINES; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    i_valid = 0; i_sof = 0;
                    i_trigger = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                inw = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
                if (inw) begin r = pick(ir);  g = pick(ig); b = pick(ib); end
                else     begin r = pick(orr); g = pick(og); b = pick(ob); end
                tick();
                i_valid = 1; i_sof = (x == 0) && (y == 0);
                i_R = 6'(r); i_G = 6'(g); i_B = 6'(b);
                i_trigger = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                if (inw) begin sr += r; sg += g; sb += b; cnt++; end
            end
        end

        tick();
        i_valid = 1; i_sof = 1; i_trigger = 0;
        i_R = 6'($urandom_range(0, 63)); i_G = 6'($urandom_range(0, 63)); i_B = 6'($urandom_range(0, 63));
        @(negedge sys_clk);

        for (int n = 1; n <= 40; n++) begin
            tick();
            sys_rst_n = (n == rst_at) ? 1'b0 : 1'b1;
            if (junk && n <= 20) begin
                i_valid = 1'($urandom_range(0, 1)); i_sof = 1'($urandom_range(0, 1));
                i_trigger = 1'($urandom_range(0, 1));
                i_R = 6'($urandom_range(0, 63)); i_G = 6'($urandom_range(0, 63)); i_B = 6'($urandom_range(0, 63));
            end else begin
                i_valid = 0; i_sof = 0; i_trigger = 0;
            end
            @(negedge sys_clk);
            if (o_done) begin ndone++; if (tdone < 0) tdone = n; end
            if (o_err)  begin nerr++;  if (terr < 0)  terr = n; end
        end

        tot = sr + sg + sb;
        exp_err = (cnt == 0) || (tot == 0);
        if (rst_at > 0) begin
            exp_r = 21; exp_g = 21; exp_b = 21;
            check({tag, " done_count"}, ndone, 0);
            check({tag, " err_count"}, nerr, 0);
        end else if (exp_err) begin
            check({tag, " err_count"}, nerr, 1);
            check({tag, " err_latency"}, terr, 1);
            check({tag, " done_count"}, ndone, 0);
        end else begin
            exp_r = int'((sr * 64) / tot); if (exp_r > 63) exp_r = 63;
            exp_g = int'((sg * 64) / tot); if (exp_g > 63) exp_g = 63;
            exp_b = int'((sb * 64) / tot); if (exp_b > 63) exp_b = 63;
            check({tag, " done_count"}, ndone, 1);
            check({tag, " done_latency"}, tdone, 23);
            check({tag, " err_count"}, nerr, 0);
        end
        check({tag, " R0"}, o_R0, exp_r);
        check({tag, " G0"}, o_G0, exp_g);
        check({tag, " B0"}, o_B0, exp_b);
        check({tag, " busy_idle"}, o_busy, 0);
    endtask

    initial begin
        sys_rst_n = 0; i_valid = 0; i_sof = 0; i_trigger = 0;
        i_R = 0; i_G = 0; i_B = 0; i_x0 = 0; i_y0 = 0; i_x1 = 0; i_y1 = 0;
        repeat (3) tick();
        sys_rst_n = 1;
        @(negedge sys_clk);
        check("reset R0", o_R0, 21);
        check("reset G0", o_G0, 21);
        check("reset B0", o_B0, 21);
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset err", o_err, 0);

        do_capture("ratio",   2, 2, 3, 3,  40, 10, 14,  -1, -1, -1, 0, 0);
        do_capture("red",     2, 2, 3, 3,  63,  0,  0,  -1, -1, -1, 0, 0);
        do_capture("grey",    2, 2, 3, 3,  21, 21, 21,  63,  0,  0, 0, 0);
        do_capture("black",   1, 1, 4, 2,   0,  0,  0,  -1, -1, -1, 0, 0);
        do_capture("x1_lt_x0", 5, 0, 2, 3, -1, -1, -1,  -1, -1, -1, 0, 0);
        do_capture("junk",    0, 1, 6, 2,  50, 30,  9,  -1, -1, -1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            int ax, bx, ay, by;
            ax = $urandom_range(0, 7); bx = $urandom_range(ax, 7);
            ay = $urandom_range(0, 3); by = $urandom_range(ay, 3);
            do_capture("random", ax, ay, bx, by, -1, -1, -1, -1, -1, -1, 0, 0);
        end
        do_capture("rst_mid_div", 2, 2, 3, 3, 40, 10, 14, -1, -1, -1, 0, 10);
        do_capture("after_rst", 0, 0, 7, 3, -1, -1, -1, -1, -1, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
